regs_dump: RTL and testbench

- Debug reader for the picoMIPS 32 x n general-purpose register file. It is the read-side counterpart to the datapath's register writes.
- On a start pulse it walks register addresses FIRST..LAST, drives the file's read address and captures the combinational read data.
- Each value is emitted with its address as one beat of a valid/ready stream, for a host UART or trace buffer.
- Sits beside the CPU. While busy is high, a top-level mux hands it the Raddr1 port and the CPU is held.

---
 rtl/regs_dump_pkg.sv | 15 +
 rtl/regs_dump.sv | 125 ++++++++++++
 tb/tb_regs_dump.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_dump_pkg.sv
// Shared constants and FSM state type for the register-file dump reader.
package regs_dump_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/regs_dump.sv
// Walks register addresses FIRST..LAST and streams {addr, value} beats over valid/ready.
// Optional trailing XOR checksum beat is enabled by defining REGS_DUMP_CSUM_EN.
module regs_dump
    import regs_dump_pkg::*;
#(
    parameter int n     = 8,
    parameter int FIRST = 1,
    parameter int LAST  = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [REG_ADDR_W-1:0] raddr,
    input  logic [n-1:0]          rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_addr,
    output logic [n-1:0]          out_data,
    output logic                  out_last,
    output logic [2:0]            dbg_state
);

    // Stream handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // once out_valid is high, out_addr/out_data/out_last hold until that transfer.

    localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST);
    localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST);

    state_t                r_state;
    logic [REG_ADDR_W-1:0] r_idx;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [REG_ADDR_W-1:0] r_out_addr;
    logic [n-1:0]          r_out_data;
    logic                  w_hs;
`ifdef REGS_DUMP_CSUM_EN
    logic [n-1:0]          r_csum;
`endif

    assign w_hs = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= FIRST_A;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
`ifdef REGS_DUMP_CSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_idx   <= FIRST_A;
`ifdef REGS_DUMP_CSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                LOAD: begin
                    r_out_data  <= rdata;
                    r_out_addr  <= r_idx;
                    r_out_valid <= 1'b1;
`ifdef REGS_DUMP_CSUM_EN
                    r_out_last  <= 1'b0;
                    r_csum      <= r_csum ^ rdata;
`else
                    r_out_last  <= (r_idx == LAST_A);
`endif
                    r_state     <= SEND;
                end
                SEND: begin
                    if (w_hs) begin
                        if (r_idx != LAST_A) begin
                            r_out_valid <= 1'b0;
                            r_idx       <= r_idx + 1'b1;
                            r_state     <= LOAD;
                        end else begin
`ifdef REGS_DUMP_CSUM_EN
                            // Checksum beat is presented immediately, no extra LOAD cycle.
                            r_out_valid <= 1'b1;
                            r_out_addr  <= '0;
                            r_out_data  <= r_csum;
                            r_out_last  <= 1'b1;
                            r_state     <= CSUM;
`else
                            r_out_valid <= 1'b0;
                            r_state     <= DONE;
`endif
                        end
                    end
                end
`ifdef REGS_DUMP_CSUM_EN
                CSUM: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        r_state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_idx   <= FIRST_A;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign raddr     = r_idx;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_regs_dump.sv
// Self-checking bench for regs_dump: a full-range instance and a single-register instance.
module tb_regs_dump;

  localparam int W = 14;  // {last, addr[4:0], data[7:0]}
`ifdef REGS_DUMP_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [7:0] gpr [32];

  // full-range instance
  logic start, busy, done, out_valid, out_ready, out_last;
  logic [4:0] raddr, out_addr;
  logic [7:0] rdata, out_data;
  logic [2:0] dbg_state;

  // single-register instance
  logic start1, busy1, done1, out_valid1, out_ready1, out_last1;
  logic [4:0] raddr1, out_addr1;
  logic [7:0] rdata1, out_data1;
  logic [2:0] dbg_state1;

  assign rdata  = gpr[raddr];
  assign rdata1 = gpr[raddr1];

  regs_dump #(.n(8), .FIRST(1), .LAST(31)) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .raddr(raddr), .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .dbg_state(dbg_state)
  );

  regs_dump #(.n(8), .FIRST(7), .LAST(7)) u_one (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .raddr(raddr1), .rdata(rdata1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_addr(out_addr1), .out_data(out_data1), .out_last(out_last1), .dbg_state(dbg_state1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- observed beats ----------------
  logic [W-1:0] got_q[$];
  int           got_t[$];
  logic [W-1:0] got1_q[$];
  int           done_cnt = 0;
  int           done_t = 0;
  int           done1_cnt = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_addr, out_data});
      got_t.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_t = cyc;
    end
    if (out_valid1 && out_ready1) got1_q.push_back({out_last1, out_addr1, out_data1});
    if (done1) done1_cnt++;
  end

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];

  task automatic build_model(input int first, input int last);
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    for (int a = first; a <= last; a++) begin
      exp_q.push_back({(a == last) && !CSUM_ON, 5'(a), gpr[a]});
      x = x ^ gpr[a];
    end
    if (CSUM_ON) exp_q.push_back({1'b1, 5'd0, x});
  endtask

  // ---------------- drivers ----------------
  task automatic run_dump(input bit rnd, input int budget, output int s, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; start1 = 1'b0;
    out_ready = 1'b0; out_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, out_valid, out_last} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, out_valid, out_last});
    end
    n_checks++;
    if ({out_addr, out_data} !== 13'd0) begin
      n_fail++; $display("FAIL reset_beat: got addr %0d data %h expected 0/00", out_addr, out_data);
    end
    n_checks++;
    if (raddr !== 5'd1 || raddr1 !== 5'd7) begin
      n_fail++; $display("FAIL reset_raddr: got %0d/%0d expected 1/7", raddr, raddr1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_full_dump();
    int s; bit ok; int last_i;
    for (int k = 0; k < 32; k++) gpr[k] = 8'(3 * k);
    build_model(1, 31);
    got_q.delete(); got_t.delete();
    run_dump(1'b0, 200, s, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_timeout: no done within budget"); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL full_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL full_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_t.size() > 0) begin
      n_checks++;
      if (got_t[0] != s + 2) begin
        n_fail++; $display("FAIL full_first_latency: got cycle %0d expected %0d", got_t[0], s + 2);
      end
      for (int i = 1; i < got_t.size(); i++) begin
        n_checks++;
        if (got_t[i] - got_t[i-1] != ((CSUM_ON && i == 31) ? 1 : 2)) begin
          n_fail++; $display("FAIL full_rate[%0d]: got gap %0d expected %0d", i, got_t[i] - got_t[i-1],
                             (CSUM_ON && i == 31) ? 1 : 2);
        end
      end
      last_i = got_t.size() - 1;
      n_checks++;
      if (done_t != got_t[last_i] + 1) begin
        n_fail++; $display("FAIL full_done_time: got cycle %0d expected %0d", done_t, got_t[last_i] + 1);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int d0; int hold; bit ok;
    for (int k = 0; k < 32; k++) gpr[k] = 8'(3 * k);
    build_model(1, 31);
    got_q.delete(); got_t.delete();
    d0 = done_cnt; hold = 0; ok = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (out_valid && out_addr == 5'd4 && hold < 5) begin
        out_ready = 1'b0;
        hold++;
        gpr[4] = 8'($urandom_range(0, 255));
        @(negedge clk);
        n_checks++;
        if (out_addr !== 5'd4 || out_data !== 8'd12) begin
          n_fail++; $display("FAIL bp_hold: got addr %0d data %h expected 4/0c", out_addr, out_data);
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      #1;
      if (done_cnt > d0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    gpr[4] = 8'd12;
    n_checks++;
    if (!ok || hold != 5) begin
      n_fail++; $display("FAIL bp_run: got done %b hold %0d expected 1/5", ok, hold);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int d0; bit pulsed; bit ok;
    for (int k = 0; k < 32; k++) gpr[k] = 8'($urandom_range(0, 255));
    build_model(1, 31);
    got_q.delete(); got_t.delete();
    d0 = done_cnt; pulsed = 1'b0; ok = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      start = (got_q.size() == 10 && !pulsed);
      if (start) pulsed = 1'b1;
      @(negedge clk); #1;
      if (done_cnt > d0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (!ok || !pulsed) begin n_fail++; $display("FAIL swb_run: got done %b pulsed %b expected 1/1", ok, pulsed); end
    n_checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL swb_done: got %0d pulses busy %b expected 1/0", done_cnt - d0, busy);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL swb_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL swb_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    int d0; bit seen; int s; bit ok;
    for (int k = 0; k < 32; k++) gpr[k] = 8'(3 * k);
    d0 = done_cnt; seen = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid && out_addr == 5'd10) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_reach: beat addr 10 not seen expected seen"); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: got valid %b busy %b expected 0/0", out_valid, busy);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses expected 0", done_cnt - d0); end
    @(posedge clk); #1;
    build_model(1, 31);
    got_q.delete(); got_t.delete();
    run_dump(1'b1, 400, s, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rst_restart: got done %b beats %0d expected 1/%0d", ok, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rst_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_single();
    int d0; bit ok;
    gpr[7] = 8'h5C;
    build_model(7, 7);
    got1_q.delete();
    d0 = done1_cnt; ok = 1'b0;
    out_ready1 = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (done1_cnt > d0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || got1_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL single_run: got done %b beats %0d expected 1/%0d", ok, got1_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got1_q.size(); i++) begin
      n_checks++;
      if (got1_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_beat[%0d]: got %h expected %h", i, got1_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0 || done1_cnt - d0 != 1) begin
      n_fail++; $display("FAIL single_end: got busy %b pulses %0d expected 0/1", busy1, done1_cnt - d0);
    end
  endtask

  task automatic test_checksum(input bit all_a5, input bit rnd);
    int s; bit ok;
    for (int k = 0; k < 32; k++) gpr[k] = all_a5 ? 8'hA5 : 8'($urandom_range(0, 255));
    build_model(1, 31);
    got_q.delete(); got_t.delete();
    run_dump(rnd, 400, s, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL csum_run: got done %b beats %0d expected 1/%0d", ok, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL csum_beat[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) gpr[k] = 8'h00;
    test_reset();
    test_full_dump();
    @(posedge clk); #1;
    test_backpressure();
    @(posedge clk); #1;
    test_start_while_busy();
    @(posedge clk); #1;
    test_reset_mid_dump();
    @(posedge clk); #1;
    test_single();
    test_checksum(1'b1, 1'b0);
    test_checksum(1'b0, 1'b1);
    test_checksum(1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
